// File: rtl/parking_display.sv
// Parking-lot free-space display: scans four seven-segment digits from the
// 500 Hz strobe and shows "P nn", "FULL" (blinking at 2 Hz) or "P --" on overflow.
module parking_display #(
    parameter int CAPACITY = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_500Hz,
    input  logic       clk_2Hz,
    input  logic [6:0] free_count,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       err
);

    // Glyph codes used internally before segment encoding.
    localparam logic [3:0] GLYPH_P     = 4'd10;
    localparam logic [3:0] GLYPH_F     = 4'd11;
    localparam logic [3:0] GLYPH_U     = 4'd12;
    localparam logic [3:0] GLYPH_L     = 4'd13;
    localparam logic [3:0] GLYPH_DASH  = 4'd14;
    localparam logic [3:0] GLYPH_BLANK = 4'd15;

    localparam logic [6:0] CAP_VALUE = 7'(CAPACITY);

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_FULL   = 2'd1,
        MODE_ERR    = 2'd2
    } mode_t;

    // Active-low segment pattern {g,f,e,d,c,b,a} for each glyph code.
    function automatic logic [6:0] seg_encode(input logic [3:0] glyph);
        logic [6:0] pattern;
        case (glyph)
            4'd0:        pattern = 7'b1000000;
            4'd1:        pattern = 7'b1111001;
            4'd2:        pattern = 7'b0100100;
            4'd3:        pattern = 7'b0110000;
            4'd4:        pattern = 7'b0011001;
            4'd5:        pattern = 7'b0010010;
            4'd6:        pattern = 7'b0000010;
            4'd7:        pattern = 7'b1111000;
            4'd8:        pattern = 7'b0000000;
            4'd9:        pattern = 7'b0010000;
            GLYPH_P:     pattern = 7'b0001100;
            GLYPH_F:     pattern = 7'b0001110;
            GLYPH_U:     pattern = 7'b1000001;
            GLYPH_L:     pattern = 7'b1000111;
            GLYPH_DASH:  pattern = 7'b0111111;
            default:     pattern = 7'b1111111;
        endcase
        return pattern;
    endfunction

    logic       prev_500_r;
    logic [1:0] idx_r;
    logic [6:0] frame_r;
    logic       shown_r;
    logic [3:0] an_r;
    logic [6:0] seg_r;
    logic       err_r;

    logic       tick_s;
    logic [1:0] idx_next_s;
    logic [6:0] frame_next_s;
    logic       shown_next_s;
    mode_t      mode_s;
    logic [3:0] tens_s;
    logic [3:0] units_s;
    logic [3:0] glyph_s;
    logic [3:0] an_next_s;
    logic [6:0] seg_next_s;
    logic       err_next_s;

    // Scan tick detection, index advance and frame latch at the 3->0 wrap.
    always_comb begin
        tick_s       = clk_500Hz & ~prev_500_r;
        idx_next_s   = idx_r;
        frame_next_s = frame_r;
        shown_next_s = shown_r | tick_s;
        if (tick_s) begin
            idx_next_s = idx_r + 2'd1;
            if (idx_r == 2'd3) begin
                frame_next_s = free_count;
            end else begin
                frame_next_s = frame_r;
            end
        end else begin
            idx_next_s = idx_r;
        end
    end

    // Mode decode and decimal split of the frame value that will be displayed.
    always_comb begin
        mode_s  = MODE_NORMAL;
        tens_s  = 4'(frame_next_s / 7'd10);
        units_s = 4'(frame_next_s - (7'(tens_s) * 7'd10));
        if (frame_next_s == 7'd0) begin
            mode_s = MODE_FULL;
        end else if (frame_next_s > CAP_VALUE) begin
            mode_s = MODE_ERR;
        end else begin
            mode_s = MODE_NORMAL;
        end
    end

    // Glyph selection for the digit being enabled next, plus enables and err.
    always_comb begin
        glyph_s    = GLYPH_BLANK;
        an_next_s  = 4'b1111;
        seg_next_s = 7'b1111111;
        err_next_s = 1'b0;
        case (mode_s)
            MODE_FULL: begin
                case (idx_next_s)
                    2'd3:    glyph_s = GLYPH_F;
                    2'd2:    glyph_s = GLYPH_U;
                    default: glyph_s = GLYPH_L;
                endcase
            end
            MODE_ERR: begin
                case (idx_next_s)
                    2'd3:    glyph_s = GLYPH_P;
                    2'd2:    glyph_s = GLYPH_BLANK;
                    default: glyph_s = GLYPH_DASH;
                endcase
            end
            default: begin
                case (idx_next_s)
                    2'd3:    glyph_s = GLYPH_P;
                    2'd2:    glyph_s = GLYPH_BLANK;
                    2'd1:    glyph_s = (tens_s == 4'd0) ? GLYPH_BLANK : tens_s;
                    default: glyph_s = units_s;
                endcase
            end
        endcase
        if (shown_next_s) begin
            seg_next_s = seg_encode(glyph_s);
            err_next_s = (mode_s == MODE_ERR);
            // FULL blinks: all digits dark while the 2 Hz wave is low.
            if ((mode_s == MODE_FULL) && !clk_2Hz) begin
                an_next_s = 4'b1111;
            end else begin
                an_next_s = ~(4'b0001 << idx_next_s);
            end
        end else begin
            seg_next_s = 7'b1111111;
            an_next_s  = 4'b1111;
            err_next_s = 1'b0;
        end
    end

    // State and registered outputs; outputs refresh every clk so the blink follows clk_2Hz.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_500_r <= 1'b0;
            idx_r      <= 2'd0;
            frame_r    <= 7'd0;
            shown_r    <= 1'b0;
            an_r       <= 4'b1111;
            seg_r      <= 7'b1111111;
            err_r      <= 1'b0;
        end else begin
            prev_500_r <= clk_500Hz;
            idx_r      <= idx_next_s;
            frame_r    <= frame_next_s;
            shown_r    <= shown_next_s;
            an_r       <= an_next_s;
            seg_r      <= seg_next_s;
            err_r      <= err_next_s;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign err = err_r;

endmodule

// File: tb/tb_parking_display.sv
// Directed self-checking bench for parking_display (CAPACITY = 20).
module tb_parking_display;

    logic       clk;
    logic       reset;
    logic       clk_500Hz;
    logic       clk_2Hz;
    logic [6:0] free_count;
    logic [3:0] an;
    logic [6:0] seg;
    logic       err;

    int checks_total;
    int checks_failed;

    localparam logic [6:0] S_0     = 7'b1000000;
    localparam logic [6:0] S_1     = 7'b1111001;
    localparam logic [6:0] S_2     = 7'b0100100;
    localparam logic [6:0] S_5     = 7'b0010010;
    localparam logic [6:0] S_7     = 7'b1111000;
    localparam logic [6:0] S_9     = 7'b0010000;
    localparam logic [6:0] S_P     = 7'b0001100;
    localparam logic [6:0] S_F     = 7'b0001110;
    localparam logic [6:0] S_U     = 7'b1000001;
    localparam logic [6:0] S_L     = 7'b1000111;
    localparam logic [6:0] S_DASH  = 7'b0111111;
    localparam logic [6:0] S_BLANK = 7'b1111111;

    parking_display #(.CAPACITY(20)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_500Hz  (clk_500Hz),
        .clk_2Hz    (clk_2Hz),
        .free_count (free_count),
        .an         (an),
        .seg        (seg),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total = checks_total + 1;
        if (obs !== exp) begin
            checks_failed = checks_failed + 1;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // One scan tick: rising edge of the 500 Hz strobe, then let it fall again.
    task automatic do_tick;
        @(negedge clk);
        clk_500Hz = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        clk_500Hz = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_digit(input string tag, input logic [3:0] exp_an,
                               input logic [6:0] exp_seg, input logic exp_err);
        check_val({tag, ".an"},  32'(an),  32'(exp_an));
        check_val({tag, ".seg"}, 32'(seg), 32'(exp_seg));
        check_val({tag, ".err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks_total  = 0;
        checks_failed = 0;
        reset      = 1'b0;
        clk_500Hz  = 1'b0;
        clk_2Hz    = 1'b1;
        free_count = 7'd7;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_digit("reset", 4'b1111, S_BLANK, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_digit("post_reset_idle", 4'b1111, S_BLANK, 1'b0);

        // First frame after reset is FULL (frame=0), then 7 latched at the wrap
        do_tick; check_digit("t1_full_L", 4'b1101, S_L, 1'b0);
        do_tick; check_digit("t2_full_U", 4'b1011, S_U, 1'b0);
        do_tick; check_digit("t3_full_F", 4'b0111, S_F, 1'b0);
        do_tick; check_digit("t4_units7", 4'b1110, S_7, 1'b0);
        do_tick; check_digit("t5_tens_blank", 4'b1101, S_BLANK, 1'b0);

        // 15: old frame 7 until wrap, then P,blank,1,5
        free_count = 7'd15;
        do_tick; check_digit("f15_old_d2", 4'b1011, S_BLANK, 1'b0);
        do_tick; check_digit("f15_old_d3", 4'b0111, S_P, 1'b0);
        do_tick; check_digit("f15_d0", 4'b1110, S_5, 1'b0);
        do_tick; check_digit("f15_d1", 4'b1101, S_1, 1'b0);
        do_tick; check_digit("f15_d2", 4'b1011, S_BLANK, 1'b0);
        do_tick; check_digit("f15_d3", 4'b0111, S_P, 1'b0);

        // 12 latched, changed to 9 mid-frame
        free_count = 7'd12;
        do_tick; check_digit("f12_d0", 4'b1110, S_2, 1'b0);
        do_tick; check_digit("f12_d1", 4'b1101, S_1, 1'b0);
        free_count = 7'd9;
        do_tick; check_digit("f12_hold_d2", 4'b1011, S_BLANK, 1'b0);
        do_tick; check_digit("f12_hold_d3", 4'b0111, S_P, 1'b0);
        do_tick; check_digit("f9_d0", 4'b1110, S_9, 1'b0);
        do_tick; check_digit("f9_d1_blank", 4'b1101, S_BLANK, 1'b0);

        // 25 exceeds capacity -> ERR; 20 clears it only at the next wrap
        free_count = 7'd25;
        do_tick; check_digit("e_old_d2", 4'b1011, S_BLANK, 1'b0);
        do_tick; check_digit("e_old_d3", 4'b0111, S_P, 1'b0);
        do_tick; check_digit("e_d0", 4'b1110, S_DASH, 1'b1);
        do_tick; check_digit("e_d1", 4'b1101, S_DASH, 1'b1);
        free_count = 7'd20;
        do_tick; check_digit("e_hold_d2", 4'b1011, S_BLANK, 1'b1);
        do_tick; check_digit("e_hold_d3", 4'b0111, S_P, 1'b1);
        do_tick; check_digit("f20_d0", 4'b1110, S_0, 1'b0);
        do_tick; check_digit("f20_d1", 4'b1101, S_2, 1'b0);

        // FULL with blinking
        free_count = 7'd0;
        do_tick; check_digit("f0_old_d2", 4'b1011, S_BLANK, 1'b0);
        do_tick; check_digit("f0_old_d3", 4'b0111, S_P, 1'b0);
        do_tick; check_digit("full_d0", 4'b1110, S_L, 1'b0);
        @(negedge clk);
        clk_2Hz = 1'b0;
        @(posedge clk);
        #1;
        check_val("blink_off_an", 32'(an), 32'(4'b1111));
        @(negedge clk);
        clk_2Hz = 1'b1;
        @(posedge clk);
        #1;
        check_digit("blink_on_d0", 4'b1110, S_L, 1'b0);
        @(negedge clk);
        clk_2Hz = 1'b0;
        do_tick;
        check_val("blink_off_tick_an", 32'(an), 32'(4'b1111));
        @(negedge clk);
        clk_2Hz = 1'b1;
        @(posedge clk);
        #1;
        check_digit("blink_on_d1", 4'b1101, S_L, 1'b0);

        // A held-high strobe yields a single tick only
        @(negedge clk);
        clk_500Hz = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_digit("held_high_one_tick", 4'b1011, S_U, 1'b0);
        @(negedge clk);
        clk_500Hz = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset mid-frame at index 2 (now show non-FULL frame first)
        free_count = 7'd15;
        do_tick;                                   // idx 3, FULL F
        do_tick; check_digit("pre_rst_d0", 4'b1110, S_5, 1'b0);
        do_tick;
        do_tick; check_digit("pre_rst_d2", 4'b1011, S_BLANK, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_digit("async_reset", 4'b1111, S_BLANK, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_digit("post_rst_hold", 4'b1111, S_BLANK, 1'b0);
        do_tick; check_digit("post_rst_first", 4'b1101, S_L, 1'b0);

        $display("Result: errors=%0d of %0d checks", checks_failed, checks_total);
        $finish;
    end

endmodule
